// File: rtl/legv8_pkg.sv
// Shared LEGv8 definitions: op codes, opcode fields, immediate ranges and itype encodings.
// Used by the loader, its encoder and the instruction decoder.
package legv8_pkg;

    typedef enum logic [3:0] {
        OpAdds = 4'd0,
        OpSubs = 4'd1,
        OpBr   = 4'd2,
        OpLdur = 4'd3,
        OpStur = 4'd4,
        OpAddi = 4'd5,
        OpCbz  = 4'd6,
        OpBlt  = 4'd7,
        OpB    = 4'd8,
        OpBl   = 4'd9
    } op_e;

    // Same two-bit format tags the decoder produces.
    typedef enum logic [1:0] {
        ItypeI  = 2'b00,
        ItypeDr = 2'b01,
        ItypeB  = 2'b10,
        ItypeCb = 2'b11
    } itype_e;

    localparam logic [10:0] OPC_ADDS = 11'b10101011000;
    localparam logic [10:0] OPC_SUBS = 11'b11101011000;
    localparam logic [10:0] OPC_BR   = 11'b11010110000;
    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;
    localparam logic [9:0]  OPC_ADDI = 10'b1001000100;
    localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
    localparam logic [7:0]  OPC_BLT  = 8'b01010100;
    localparam logic [5:0]  OPC_B    = 6'b000101;
    localparam logic [5:0]  OPC_BL   = 6'b100101;

    localparam logic [4:0] COND_LT = 5'b01011;

    localparam int IMM9_MIN  = -256;
    localparam int IMM9_MAX  = 255;
    localparam int IMM12_MAX = 4095;
    localparam int IMM19_MIN = -262144;
    localparam int IMM19_MAX = 262143;
    localparam int IMM26_MIN = -33554432;
    localparam int IMM26_MAX = 33554431;

    function automatic itype_e op_itype(logic [3:0] op);
        case (op)
            OpAddi:        return ItypeI;
            OpB, OpBl:     return ItypeB;
            OpCbz, OpBlt:  return ItypeCb;
            default:       return ItypeDr;
        endcase
    endfunction

endpackage

// File: rtl/legv8_encode.sv
// Combinational LEGv8 encoder: op/fields/immediate to a 32-bit word plus range and op checks.
module legv8_encode
    import legv8_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rn,
    input  logic [4:0]  rm,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        range_ok,
    output logic        op_ok
);

    logic signed [31:0] imm_s;
    assign imm_s = imm;

    always_comb begin
        word     = '0;
        range_ok = 1'b1;
        op_ok    = 1'b1;
        case (op)
            OpAdds: word = {OPC_ADDS, rm, 6'd0, rn, rd};
            OpSubs: word = {OPC_SUBS, rm, 6'd0, rn, rd};
            OpBr:   word = {OPC_BR, 5'd0, 6'd0, rn, 5'd0};
            OpLdur: begin
                range_ok = (imm_s >= IMM9_MIN) && (imm_s <= IMM9_MAX);
                word     = {OPC_LDUR, imm[8:0], 2'b00, rn, rd};
            end
            OpStur: begin
                range_ok = (imm_s >= IMM9_MIN) && (imm_s <= IMM9_MAX);
                word     = {OPC_STUR, imm[8:0], 2'b00, rn, rd};
            end
            OpAddi: begin
                range_ok = (imm_s >= 0) && (imm_s <= IMM12_MAX);
                word     = {OPC_ADDI, imm[11:0], rn, rd};
            end
            OpCbz: begin
                range_ok = (imm_s >= IMM19_MIN) && (imm_s <= IMM19_MAX);
                word     = {OPC_CBZ, imm[18:0], rd};
            end
            OpBlt: begin
                range_ok = (imm_s >= IMM19_MIN) && (imm_s <= IMM19_MAX);
                word     = {OPC_BLT, imm[18:0], COND_LT};
            end
            OpB: begin
                range_ok = (imm_s >= IMM26_MIN) && (imm_s <= IMM26_MAX);
                word     = {OPC_B, imm[25:0]};
            end
            OpBl: begin
                range_ok = (imm_s >= IMM26_MIN) && (imm_s <= IMM26_MAX);
                word     = {OPC_BL, imm[25:0]};
            end
            default: op_ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/legv8_program_loader.sv
// Sequential LEGv8 encoder/loader writing a program into imem at consecutive word addresses.
// Optional write readback check enabled by defining LEGV8_LOADER_READBACK_EN.
module legv8_program_loader
    import legv8_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rn,
    input  logic [4:0]        in_rm,
    input  logic [31:0]       in_imm,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic [31:0]       imem_rdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] word_count,
    output logic              err_range,
    output logic              err_op,
    output logic              err_verify
);

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StAccept    = 3'd1,
        StEncode    = 3'd2,
        StWrite     = 3'd3,
        StDone      = 3'd4
`ifdef LEGV8_LOADER_READBACK_EN
        ,
        StVerifyRd  = 3'd5,
        StVerifyCmp = 3'd6
`endif
    } state_e;

    localparam logic [ADDR_W-1:0] DEPTH_W = ADDR_W'(DEPTH);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              err_range_q, err_range_d;
    logic              err_op_q, err_op_d;
    logic              err_verify_q, err_verify_d;
    logic              desc_load;

    logic [3:0]  op_q;
    logic [4:0]  rd_q, rn_q, rm_q;
    logic [31:0] imm_q;
    logic        last_q;

    logic [31:0] enc_word;
    logic        enc_range_ok;
    logic        enc_op_ok;

    legv8_encode u_encode (
        .op       (op_q),
        .rd       (rd_q),
        .rn       (rn_q),
        .rm       (rm_q),
        .imm      (imm_q),
        .word     (enc_word),
        .range_ok (enc_range_ok),
        .op_ok    (enc_op_ok)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        count_d      = count_q;
        wdata_d      = wdata_q;
        err_range_d  = err_range_q;
        err_op_d     = err_op_q;
        err_verify_d = err_verify_q;
        desc_load    = 1'b0;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d      = StAccept;
                    addr_d       = {base_addr[ADDR_W-1:2], 2'b00};
                    count_d      = '0;
                    err_range_d  = 1'b0;
                    err_op_d     = 1'b0;
                    err_verify_d = 1'b0;
                end
            end
            StAccept: begin
                if (in_valid) begin
                    desc_load = 1'b1;
                    state_d   = StEncode;
                end
            end
            StEncode: begin
                wdata_d = enc_word;
                if (enc_op_ok && enc_range_ok) begin
                    state_d = StWrite;
                end else begin
                    if (!enc_op_ok) err_op_d = 1'b1;
                    else            err_range_d = 1'b1;
                    state_d = last_q ? StDone : StAccept;
                end
            end
`ifdef LEGV8_LOADER_READBACK_EN
            StWrite:    state_d = StVerifyRd;
            StVerifyRd: state_d = StVerifyCmp;
            StVerifyCmp: begin
                if (imem_rdata != wdata_q) err_verify_d = 1'b1;
                addr_d  = addr_q + ADDR_W'(4);
                count_d = count_q + ADDR_W'(1);
                state_d = (last_q || count_d == DEPTH_W) ? StDone : StAccept;
            end
`else
            StWrite: begin
                addr_d  = addr_q + ADDR_W'(4);
                count_d = count_q + ADDR_W'(1);
                state_d = (last_q || count_d == DEPTH_W) ? StDone : StAccept;
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            count_q      <= '0;
            wdata_q      <= '0;
            err_range_q  <= 1'b0;
            err_op_q     <= 1'b0;
            err_verify_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            count_q      <= count_d;
            wdata_q      <= wdata_d;
            err_range_q  <= err_range_d;
            err_op_q     <= err_op_d;
            err_verify_q <= err_verify_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q   <= '0;
            rd_q   <= '0;
            rn_q   <= '0;
            rm_q   <= '0;
            imm_q  <= '0;
            last_q <= 1'b0;
        end else if (desc_load) begin
            op_q   <= in_op;
            rd_q   <= in_rd;
            rn_q   <= in_rn;
            rm_q   <= in_rm;
            imm_q  <= in_imm;
            last_q <= in_last;
        end
    end

    assign in_ready   = (state_q == StAccept);
    assign imem_we    = (state_q == StWrite);
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign busy       = (state_q != StIdle) && (state_q != StDone);
    assign done       = (state_q == StDone);
    assign word_count = count_q;
    assign err_range  = err_range_q;
    assign err_op     = err_op_q;

`ifdef LEGV8_LOADER_READBACK_EN
    assign err_verify = err_verify_q;
`else
    logic unused_rdata;
    assign unused_rdata = ^{imem_rdata, err_verify_q};
    assign err_verify   = 1'b0;
`endif

endmodule

// File: tb/tb_legv8_program_loader.sv
// Directed bench for legv8_program_loader with a small imem model and write log.
module tb_legv8_program_loader;
    import legv8_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] base_addr = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_op = '0;
    logic [4:0]  in_rd = '0, in_rn = '0, in_rm = '0;
    logic [31:0] in_imm = '0;
    logic        in_last = 1'b0;
    logic        imem_we;
    logic [15:0] imem_addr;
    logic [31:0] imem_wdata;
    logic [31:0] imem_rdata;
    logic        busy, done;
    logic [15:0] word_count;
    logic        err_range, err_op, err_verify;

    int total = 0;
    int bad = 0;

    logic [31:0] mem [0:255];
    logic        corrupt = 1'b0;
    logic [15:0] wa_q [$];
    logic [31:0] wd_q [$];

    always #5 clk = ~clk;

    legv8_program_loader #(.ADDR_W(16), .DEPTH(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .base_addr  (base_addr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rd      (in_rd),
        .in_rn      (in_rn),
        .in_rm      (in_rm),
        .in_imm     (in_imm),
        .in_last    (in_last),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .imem_rdata (imem_rdata),
        .busy       (busy),
        .done       (done),
        .word_count (word_count),
        .err_range  (err_range),
        .err_op     (err_op),
        .err_verify (err_verify)
    );

    assign imem_rdata = mem[imem_addr[9:2]] ^ {31'd0, corrupt};

    always @(posedge clk) begin
        if (imem_we && reset_n) begin
            mem[imem_addr[9:2]] <= imem_wdata;
            wa_q.push_back(imem_addr);
            wd_q.push_back(imem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_prog(input logic [15:0] addr);
        wa_q.delete();
        wd_q.delete();
        base_addr = addr;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Returns one cycle after the handshake edge (DUT in encode).
    task automatic send(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rn,
                        input logic [4:0] rm, input logic [31:0] imm, input logic last);
        int n = 0;
        in_valid = 1'b1;
        in_op = op;
        in_rd = rd;
        in_rn = rn;
        in_rm = rm;
        in_imm = imm;
        in_last = last;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        check("handshake_timeout", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 100) begin
            step();
            n++;
        end
        check("done", {31'd0, done}, 32'd1);
    endtask

    task automatic check_write(input int idx, input logic [15:0] addr, input logic [31:0] data);
        if (wa_q.size() > idx) begin
            check("write_addr", {16'd0, wa_q[idx]}, {16'd0, addr});
            check("write_data", wd_q[idx], data);
        end else begin
            check("write_missing", wa_q.size(), idx + 1);
        end
    endtask

    initial begin
        // Reset state
        #3;
        check("rst_we", {31'd0, imem_we}, 32'd0);
        check("rst_addr", {16'd0, imem_addr}, 32'd0);
        check("rst_count", {16'd0, word_count}, 32'd0);
        check("rst_flags", {26'd0, busy, done, in_ready, err_range, err_op, err_verify}, 32'd0);
        #10 reset_n = 1'b1;
        step();

        // ADDI X1,X2,#5 at 0x0040, write two cycles after handshake
        start_prog(16'h0043);
        check("busy_after_start", {31'd0, busy}, 32'd1);
        send(OpAddi, 5'd1, 5'd2, 5'd0, 32'd5, 1'b1);
        step();
        check("latency_we", {31'd0, imem_we}, 32'd1);
        wait_done();
        check("p1_writes", wa_q.size(), 32'd1);
        check_write(0, 16'h0040, 32'h91001441);
        check("p1_count", {16'd0, word_count}, 32'd1);
        check("p1_addr_next", {16'd0, imem_addr}, 32'h44);
        check("p1_busy", {31'd0, busy}, 32'd0);

        // ADDS X3,X1,X2 then LDUR X4,[X5,#-8]
        start_prog(16'h0000);
        send(OpAdds, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
        send(OpLdur, 5'd4, 5'd5, 5'd0, -32'sd8, 1'b1);
        wait_done();
        check_write(0, 16'h0000, 32'hAB020023);
        check_write(1, 16'h0004, 32'hF85F80A4);
        check("p2_count", {16'd0, word_count}, 32'd2);

        // B #-1 then B.LT #2, with a start pulse while busy that must be ignored
        start_prog(16'h0100);
        send(OpB, 5'd0, 5'd0, 5'd0, -32'sd1, 1'b0);
        base_addr = 16'h0500;
        start = 1'b1;
        step();
        start = 1'b0;
        send(OpBlt, 5'd0, 5'd0, 5'd0, 32'd2, 1'b1);
        wait_done();
        check_write(0, 16'h0100, 32'h17FFFFFF);
        check_write(1, 16'h0104, 32'h5400004B);

        // ADDI imm=4096 is rejected; next instruction lands at the same address
        start_prog(16'h0200);
        send(OpAddi, 5'd1, 5'd2, 5'd0, 32'd4096, 1'b0);
        step();
        step();
        check("range_err", {31'd0, err_range}, 32'd1);
        check("range_no_write", wa_q.size(), 32'd0);
        check("range_addr_hold", {16'd0, imem_addr}, 32'h200);
        send(OpAddi, 5'd1, 5'd2, 5'd0, 32'd5, 1'b1);
        wait_done();
        check_write(0, 16'h0200, 32'h91001441);
        check("range_sticky", {31'd0, err_range}, 32'd1);

        // Unknown op: sticky err_op, no write; err_range cleared by the new start
        start_prog(16'h0300);
        check("range_cleared", {31'd0, err_range}, 32'd0);
        send(4'd12, 5'd1, 5'd1, 5'd1, 32'd0, 1'b1);
        wait_done();
        check("op_err", {31'd0, err_op}, 32'd1);
        check("op_no_write", wa_q.size(), 32'd0);
        check("op_count", {16'd0, word_count}, 32'd0);

        // DEPTH=4: four writes, then done with in_ready low
        start_prog(16'h0400);
        for (int i = 0; i < 4; i++) begin
            send(OpAdds, 5'(i), 5'd0, 5'd0, 32'd0, 1'b0);
        end
        wait_done();
        in_valid = 1'b1;
        repeat (5) step();
        check("depth_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        check("depth_writes", wa_q.size(), 32'd4);
        check("depth_count", {16'd0, word_count}, 32'd4);
        for (int i = 0; i < 4; i++) begin
            check_write(i, 16'h0400 + 16'(4 * i), 32'hAB000000 | i);
        end

        // Readback: corrupted bit 0 flags err_verify; without the option it stays 0
        corrupt = 1'b1;
        start_prog(16'h0080);
        send(OpSubs, 5'd7, 5'd8, 5'd9, 32'd0, 1'b1);
        wait_done();
        corrupt = 1'b0;
        check_write(0, 16'h0080, 32'hEB090107);
`ifdef LEGV8_LOADER_READBACK_EN
        check("verify_err", {31'd0, err_verify}, 32'd1);
`else
        check("verify_off", {31'd0, err_verify}, 32'd0);
`endif

        // Reset asserted while the write strobe is high
        start_prog(16'h0600);
        send(OpAddi, 5'd1, 5'd2, 5'd0, 32'd5, 1'b0);
        step();
        check("pre_rst_we", {31'd0, imem_we}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("rst_mid_we", {31'd0, imem_we}, 32'd0);
        check("rst_mid_addr", {16'd0, imem_addr}, 32'd0);
        check("rst_mid_wdata", imem_wdata, 32'd0);
        check("rst_mid_flags", {26'd0, busy, done, in_ready, err_range, err_op, err_verify},
              32'd0);
        check("rst_mid_count", {16'd0, word_count}, 32'd0);
        step();
        reset_n = 1'b1;
        step();
        check("post_rst_idle", {30'd0, busy, done}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/legv8_program_loader.md
Name: legv8_program_loader

Overview:
- Sequential LEGv8 instruction encoder and loader. It is the writer side of the instruction decoder.
- Accepts a stream of symbolic instructions (op, register fields, immediate) over a valid/ready handshake.
- Encodes each one into a 32-bit LEGv8 word and writes it into instruction memory at consecutive word addresses.
- Used to preload imem for CPU bring-up and test programs.

Parameters:
- ADDR_W, 16, imem byte-address width.
- DEPTH, 1024, maximum number of words written per program.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse: begin a program at base_addr
- base_addr  in  ADDR_W  byte address of the first word; bits [1:0] ignored
- in_valid  in  1  instruction descriptor valid
- in_ready  out  1  loader can accept a descriptor
- in_op  in  4  legv8_pkg op code
- in_rd  in  5  Rd/Rt field
- in_rn  in  5  Rn field
- in_rm  in  5  Rm field
- in_imm  in  32  signed immediate or offset, in words for branches
- in_last  in  1  final descriptor of the program
- imem_we  out  1  imem write strobe
- imem_addr  out  ADDR_W  imem byte address
- imem_wdata  out  32  encoded instruction
- imem_rdata  in  32  imem read data; used only with readback
- busy  out  1  program in progress
- done  out  1  program finished; held until the next start
- word_count  out  ADDR_W  words written in the current program
- err_range  out  1  sticky: an immediate was out of range
- err_op  out  1  sticky: an unknown op was received
- err_verify  out  1  sticky: readback mismatch

Behaviour:
- Reset (async, immediate): state IDLE. All outputs 0, including imem_we, imem_addr and word_count.
- FSM states: IDLE, ACCEPT, ENCODE, WRITE, DONE; VERIFY_RD and VERIFY_CMP exist only under the option.
- IDLE:
  - start → ACCEPT.
  - imem_addr loads {base_addr[ADDR_W-1:2],2'b00}.
  - word_count and all err_* flags clear.
  - busy is 1 from the next cycle.
- ACCEPT:
  - in_ready=1.
  - On in_valid&&in_ready, register the descriptor → ENCODE.
- ENCODE:
  - Register the encoded word and the range/op check.
  - If the check is OK → WRITE.
  - Otherwise set the sticky error and skip the write; go to DONE if last, else ACCEPT.
- WRITE:
  - imem_we=1 for exactly one cycle.
  - Next cycle: imem_addr += 4 (wraps modulo 2^ADDR_W) and word_count += 1.
  - Then → DONE if last or word_count reaches DEPTH, else ACCEPT.
- Latency: handshake at cycle N, imem_we at N+2. Throughput is one word per 3 cycles.
- DONE: done=1, busy=0, in_ready=0. start → new program.
- start asserted while busy: ignored.
- A descriptor that arrives after DEPTH words: never accepted (in_ready=0 in DONE).
- Encodings:
  - ADDS: 10101011000 | Rm | shamt=0 | Rn | Rd
  - SUBS: 11101011000 | Rm | shamt=0 | Rn | Rd
  - BR: 11010110000 | Rm=0 | shamt=0 | Rn | Rd=0
  - LDUR: 11111000010 | imm9 | 00 | Rn | Rt
  - STUR: 11111000000 | imm9 | 00 | Rn | Rt
  - ADDI: 1001000100 | imm12 | Rn | Rd
  - CBZ: 10110100 | imm19 | Rt
  - B.LT: 01010100 | imm19 | 01011
  - B: 000101 | imm26
  - BL: 100101 | imm26
- Range rules:
  - imm9: signed, −256..255.
  - imm12: unsigned, 0..4095.
  - imm19: signed, −2^18..2^18−1.
  - imm26: signed, −2^25..2^25−1.
  - Fields are taken as two's-complement truncations after the check passes.

Optional Feature:
- Macro: LEGV8_LOADER_READBACK_EN.
- Defined:
  - After WRITE, go to VERIFY_RD: imem_addr held at the written address, imem_we=0.
  - Then VERIFY_CMP: compare imem_rdata with the written word; a mismatch sets err_verify.
  - The address increments after the compare.
  - Latency to the next in_ready becomes 5 cycles.
- Undefined: no verify states, imem_rdata unused, err_verify tied to 0.

Decomposition:
- legv8_pkg holds:
  - op enum: ADDS, SUBS, BR, LDUR, STUR, ADDI, CBZ, BLT, B, BL.
  - opcode constants for each width (11/10/8/6 bits).
  - COND_LT=5'b01011.
  - Immediate range constants.
  - The itype encodings shared with the decoder (I=00, D/R=01, B=10, CB=11).
- Sub-module legv8_encode: purely combinational. Maps op/fields/imm to {word, range_ok, op_ok}. Shared with future assembler benches.

Test Plan:
- base 0x0040; ADDI X1,X2,#5 with last → imem_we at 0x0040, wdata 0x91001441, done=1, word_count=1.
- ADDS X3,X1,X2 then LDUR X4,[X5,#−8] → words 0xAB020023 @0x0, 0xF85F80A4 @0x4.
- B #−1 then B.LT #2 → 0x17FFFFFF, 0x5400004B.
- ADDI imm=4096 → no imem_we, err_range=1, imem_addr unchanged; the next valid instruction is written at the same address.
- DEPTH=4 with 6 descriptors → exactly 4 writes, then done=1, in_ready=0.
- reset_n low during WRITE → imem_we drops combinationally, all outputs 0, state IDLE.
- Readback option: imem model corrupts bit 0 → err_verify=1.
